cheshire_vctxt_sched: RTL and testbench

Time-slice scheduler that shares the hart among the virtual supervisor contexts of a vCLIC-enabled Cheshire (Clic, ClicVsclic, ClicNumVsctxts = 4). It sequences contexts round-robin with a per-context slice length, and requests each context switch from the hypervisor-side handler through a req/ack handshake. With preemption compiled in, a higher-priority pending interrupt in a non-active context cuts the current slice short.

---
 rtl/cheshire_pkg.sv | 15 +
 rtl/cheshire_vctxt_rr_pick.sv | 35 +++
 rtl/cheshire_vctxt_sched.sv | 197 +++++++++++++++++++
 tb/tb_cheshire_vctxt_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cheshire_pkg.sv
// Shared types and constants for the Cheshire virtual-context time-slice scheduler.
package cheshire_pkg;

    localparam int unsigned VctxtSliceWidth = 16;
    localparam int unsigned VctxtNumCtxts   = 4;

    typedef enum logic [1:0] {
        VCTXT_IDLE   = 2'd0,
        VCTXT_SWITCH = 2'd1,
        VCTXT_RUN    = 2'd2
    } vctxt_sched_state_e;

    typedef logic [$clog2(VctxtNumCtxts)-1:0] vctxt_idx_t;

endpackage

// File: rtl/cheshire_vctxt_rr_pick.sv
// Round-robin picker: first set bit of mask at or after start, wrapping at NumCtxts-1.
module cheshire_vctxt_rr_pick #(
    parameter  int unsigned NumCtxts = 4,
    localparam int unsigned IdxWidth = $clog2(NumCtxts)
) (
    input  logic [NumCtxts-1:0] mask,
    input  logic [IdxWidth-1:0] start,
    output logic [IdxWidth-1:0] idx,
    output logic                found
);

    int unsigned cand_s;

    // Scan the mask from start, taking the first hit.
    always_comb begin
        idx    = {IdxWidth{1'b0}};
        found  = 1'b0;
        cand_s = 32'd0;
        for (int unsigned k = 0; k < NumCtxts; k++) begin
            cand_s = 32'(start) + k;
            if (cand_s >= NumCtxts) begin
                cand_s = cand_s - NumCtxts;
            end else begin
                cand_s = cand_s;
            end
            if (!found && mask[cand_s[IdxWidth-1:0]]) begin
                found = 1'b1;
                idx   = cand_s[IdxWidth-1:0];
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/cheshire_vctxt_sched.sv
// Time-slice scheduler for vCLIC virtual supervisor contexts with req/ack switch handshake.
// Optional interrupt-driven preemption: define CHESHIRE_VCTXT_PREEMPT_EN.
module cheshire_vctxt_sched
    import cheshire_pkg::*;
#(
    parameter  int unsigned NumCtxts   = VctxtNumCtxts,
    parameter  int unsigned SliceWidth = VctxtSliceWidth,
    parameter  int unsigned PrioWidth  = 1,
    localparam int unsigned IdxWidth   = $clog2(NumCtxts)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [NumCtxts-1:0]            ctxt_en_i,
    input  logic [NumCtxts*SliceWidth-1:0] slice_len_i,
    input  logic [NumCtxts-1:0]            irq_pend_i,
    input  logic [NumCtxts*PrioWidth-1:0]  irq_prio_i,
    output logic                           switch_req_o,
    output logic [IdxWidth-1:0]            switch_next_o,
    input  logic                           switch_ack_i,
    output logic                           active_valid_o,
    output logic [IdxWidth-1:0]            active_ctxt_o,
    output logic                           preempt_o
);

    vctxt_sched_state_e    state_r, state_s;
    logic [SliceWidth-1:0] cnt_r, cnt_s;
    logic [IdxWidth-1:0]   active_r, active_s;
    logic [IdxWidth-1:0]   next_r, next_s;
    logic                  valid_r, valid_s;
    logic                  req_r;
    logic                  preempt_r, preempt_s;

    logic [IdxWidth-1:0]   pick_start_s, pick_idx_s;
    logic                  pick_found_s;
    logic                  pre_hit_s;
    logic [IdxWidth-1:0]   pre_idx_s;

    // A zero slice length still grants one cycle, so the counter loads max(len,1)-1.
    function automatic logic [SliceWidth-1:0] slice_load(
        input logic [NumCtxts*SliceWidth-1:0] lens,
        input logic [IdxWidth-1:0]            sel
    );
        logic [SliceWidth-1:0] len;
        len = lens[sel*SliceWidth +: SliceWidth];
        if (len == {SliceWidth{1'b0}}) begin
            return {SliceWidth{1'b0}};
        end else begin
            return len - {{(SliceWidth-1){1'b0}}, 1'b1};
        end
    endfunction

    // Initial selection scans from 0; rotation scans from the slot after the active one.
    always_comb begin
        if (state_r == VCTXT_IDLE) begin
            pick_start_s = {IdxWidth{1'b0}};
        end else if (active_r == IdxWidth'(NumCtxts - 1)) begin
            pick_start_s = {IdxWidth{1'b0}};
        end else begin
            pick_start_s = active_r + {{(IdxWidth-1){1'b0}}, 1'b1};
        end
    end

    cheshire_vctxt_rr_pick #(
        .NumCtxts (NumCtxts)
    ) i_rr_pick (
        .mask  (ctxt_en_i),
        .start (pick_start_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

`ifdef CHESHIRE_VCTXT_PREEMPT_EN
    logic [PrioWidth-1:0] pre_prio_s, act_prio_s, cand_prio_s;
    logic                 act_pend_s;

    // Highest strictly-outranking pending context wins; ties keep the lowest index.
    always_comb begin
        act_pend_s  = irq_pend_i[active_r];
        act_prio_s  = irq_prio_i[active_r*PrioWidth +: PrioWidth];
        pre_hit_s   = 1'b0;
        pre_idx_s   = {IdxWidth{1'b0}};
        pre_prio_s  = {PrioWidth{1'b0}};
        cand_prio_s = {PrioWidth{1'b0}};
        for (int unsigned j = 0; j < NumCtxts; j++) begin
            cand_prio_s = irq_prio_i[j*PrioWidth +: PrioWidth];
            if ((IdxWidth'(j) != active_r) && ctxt_en_i[j] && irq_pend_i[j] &&
                (!act_pend_s || (cand_prio_s > act_prio_s)) &&
                (!pre_hit_s || (cand_prio_s > pre_prio_s))) begin
                pre_hit_s  = 1'b1;
                pre_idx_s  = IdxWidth'(j);
                pre_prio_s = cand_prio_s;
            end else begin
                pre_hit_s = pre_hit_s;
            end
        end
    end
`else
    logic unused_irq_s;
    assign unused_irq_s = ^{irq_pend_i, irq_prio_i};
    assign pre_hit_s    = 1'b0;
    assign pre_idx_s    = {IdxWidth{1'b0}};
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        active_s  = active_r;
        next_s    = next_r;
        valid_s   = valid_r;
        preempt_s = 1'b0;
        case (state_r)
            VCTXT_IDLE: begin
                valid_s = 1'b0;
                if (en_i && pick_found_s) begin
                    next_s  = pick_idx_s;
                    state_s = VCTXT_SWITCH;
                end else begin
                    state_s = VCTXT_IDLE;
                end
            end
            VCTXT_SWITCH: begin
                if (!switch_ack_i) begin
                    state_s = VCTXT_SWITCH;
                end else if (en_i && ctxt_en_i[next_r]) begin
                    active_s = next_r;
                    valid_s  = 1'b1;
                    cnt_s    = slice_load(slice_len_i, next_r);
                    state_s  = VCTXT_RUN;
                end else begin
                    valid_s = 1'b0;
                    state_s = VCTXT_IDLE;
                end
            end
            VCTXT_RUN: begin
                if (!en_i) begin
                    valid_s = 1'b0;
                    state_s = VCTXT_IDLE;
                end else if (!ctxt_en_i[active_r]) begin
                    if (pick_found_s) begin
                        next_s  = pick_idx_s;
                        state_s = VCTXT_SWITCH;
                    end else begin
                        valid_s = 1'b0;
                        state_s = VCTXT_IDLE;
                    end
                end else if (pre_hit_s) begin
                    next_s    = pre_idx_s;
                    preempt_s = 1'b1;
                    state_s   = VCTXT_SWITCH;
                end else if (cnt_r == {SliceWidth{1'b0}}) begin
                    if (pick_idx_s == active_r) begin
                        cnt_s = slice_load(slice_len_i, active_r);
                    end else begin
                        next_s  = pick_idx_s;
                        state_s = VCTXT_SWITCH;
                    end
                end else begin
                    cnt_s = cnt_r - {{(SliceWidth-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = VCTXT_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= VCTXT_IDLE;
            cnt_r     <= {SliceWidth{1'b0}};
            active_r  <= {IdxWidth{1'b0}};
            next_r    <= {IdxWidth{1'b0}};
            valid_r   <= 1'b0;
            req_r     <= 1'b0;
            preempt_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            active_r  <= active_s;
            next_r    <= next_s;
            valid_r   <= valid_s;
            req_r     <= (state_s == VCTXT_SWITCH);
            preempt_r <= preempt_s;
        end
    end

    assign switch_req_o   = req_r;
    assign switch_next_o  = next_r;
    assign active_valid_o = valid_r;
    assign active_ctxt_o  = active_r;
    assign preempt_o      = preempt_r;

endmodule

// File: tb/tb_cheshire_vctxt_sched.sv
// Randomized bench for cheshire_vctxt_sched against a slice-accounting reference model.
module tb_cheshire_vctxt_sched;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  ctxt_en = 4'b0000;
    logic [63:0] slice_len = 64'd0;
    logic [3:0]  irq_pend = 4'b0000;
    logic [3:0]  irq_prio = 4'b0000;
    logic        ack = 1'b0;
    logic        switch_req, active_valid, preempt;
    logic [1:0]  switch_next, active_ctxt;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_wait = 0;
    int req_age  = 0;
    bit spurious = 1'b0;

    // Model: mode 0 = nothing scheduled, 1 = request outstanding, 2 = context running.
    int m_mode = 0, m_active = 0, m_next = 0, m_used = 0, m_limit = 0;
    bit m_req = 1'b0, m_valid = 1'b0, m_pre = 1'b0;

    always #5 clk = ~clk;

    cheshire_vctxt_sched dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .ctxt_en_i      (ctxt_en),
        .slice_len_i    (slice_len),
        .irq_pend_i     (irq_pend),
        .irq_prio_i     (irq_prio),
        .switch_req_o   (switch_req),
        .switch_next_o  (switch_next),
        .switch_ack_i   (ack),
        .active_valid_o (active_valid),
        .active_ctxt_o  (active_ctxt),
        .preempt_o      (preempt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int slen(input int i);
        int l;
        l = int'(slice_len[i*16 +: 16]);
        return (l == 0) ? 1 : l;
    endfunction

    function automatic int rr_after(input int from);
        for (int k = 1; k <= N; k++) begin
            if (ctxt_en[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic int preempt_pick();
        int best = -1;
        for (int j = 0; j < N; j++) begin
            if (j != m_active && ctxt_en[j] && irq_pend[j] &&
                (!irq_pend[m_active] || irq_prio[j] > irq_prio[m_active]) &&
                (best < 0 || irq_prio[j] > irq_prio[best]))
                best = j;
        end
        return best;
    endfunction

    task automatic model_step();
        int p, pick;
        m_pre = 1'b0;
        if (rst) begin
            m_mode = 0; m_active = 0; m_next = 0; m_used = 0; m_limit = 0; m_valid = 1'b0;
        end else if (m_mode == 0) begin
            m_valid = 1'b0;
            if (en && ctxt_en != 4'b0000) begin
                m_next = rr_after(N - 1);
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (ack) begin
                if (en && ctxt_en[m_next]) begin
                    m_active = m_next; m_valid = 1'b1; m_used = 0; m_limit = slen(m_next); m_mode = 2;
                end else begin
                    m_valid = 1'b0; m_mode = 0;
                end
            end
        end else begin
`ifdef CHESHIRE_VCTXT_PREEMPT_EN
            p = preempt_pick();
`else
            p = -1;
`endif
            if (!en) begin
                m_valid = 1'b0; m_mode = 0;
            end else if (!ctxt_en[m_active]) begin
                pick = rr_after(m_active);
                if (pick >= 0) begin
                    m_next = pick; m_mode = 1;
                end else begin
                    m_valid = 1'b0; m_mode = 0;
                end
            end else if (p >= 0) begin
                m_next = p; m_mode = 1; m_pre = 1'b1;
            end else if (m_used + 1 >= m_limit) begin
                pick = rr_after(m_active);
                if (pick == m_active) begin
                    m_used = 0; m_limit = slen(m_active);
                end else begin
                    m_next = pick; m_mode = 1;
                end
            end else begin
                m_used++;
            end
        end
        m_req = (m_mode == 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("switch_req", 32'(switch_req), 32'(m_req));
        check_eq("switch_next", 32'(switch_next), m_next);
        check_eq("active_valid", 32'(active_valid), 32'(m_valid));
        check_eq("active_ctxt", 32'(active_ctxt), m_active);
        check_eq("preempt", 32'(preempt), 32'(m_pre));
        req_age = switch_req ? req_age + 1 : 0;
        ack = !rst && ((switch_req && req_age > ack_wait) ||
                       (spurious && !switch_req && $urandom_range(0, 7) == 0));
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        int wait_n;
        rst = 1'b1;
        run(3);
        check_eq("reset_req", 32'(switch_req), 32'd0);
        check_eq("reset_valid", 32'(active_valid), 32'd0);
        rst = 1'b0;

        // Startup with two enabled contexts and 3-cycle slices.
        ctxt_en = 4'b0110; en = 1'b1; slice_len = {4{16'd3}}; ack_wait = 0;
        run(30);

        // Sole context with a zero slice length.
        ctxt_en = 4'b0001; slice_len = 64'd0;
        run(40);

        // Late acknowledge held back for 10 cycles.
        ctxt_en = 4'b0011; slice_len = {4{16'd2}}; ack_wait = 10;
        run(60);
        ack_wait = 0;

        // Disable the active context, then everything.
        ctxt_en = 4'b1010; slice_len = {4{16'd20}};
        wait_n = 0;
        while (!(active_valid && active_ctxt == 2'd1 && !switch_req) && wait_n < 100) begin
            tick(); wait_n++;
        end
        check_eq("wait_ctxt1", 32'(wait_n < 100), 32'd1);
        ctxt_en = 4'b1000;
        run(6);
        ctxt_en = 4'b0000;
        run(6);

        // Interrupt on a non-active context while ctxt 0 runs a long slice.
        ctxt_en = 4'b0101; slice_len = {4{16'd40}};
        wait_n = 0;
        while (!(active_valid && active_ctxt == 2'd0 && !switch_req) && wait_n < 100) begin
            tick(); wait_n++;
        end
        check_eq("wait_ctxt0", 32'(wait_n < 100), 32'd1);
        irq_pend = 4'b0100; irq_prio = 4'b0100;
        run(60);
        irq_pend = 4'b0000; irq_prio = 4'b0000;

        // Randomized traffic with spurious acks and occasional resets.
        spurious = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) ctxt_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) slice_len = {16'($urandom_range(0, 5)), 16'($urandom_range(0, 5)),
                                                       16'($urandom_range(0, 5)), 16'($urandom_range(0, 5))};
            if ($urandom_range(0, 3) == 0) irq_pend = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) irq_prio = 4'($urandom_range(0, 15));
            ack_wait = $urandom_range(0, 3);
            rst = ($urandom_range(0, 199) == 0);
            if (rst) ack = 1'b0;
            tick();
        end
        rst = 1'b0; spurious = 1'b0; irq_pend = 4'b0000;

        // Reset while a request is outstanding.
        en = 1'b1; ctxt_en = 4'b0011; slice_len = {4{16'd2}}; ack_wait = 50;
        wait_n = 0;
        while (!switch_req && wait_n < 100) begin
            tick(); wait_n++;
        end
        check_eq("wait_req", 32'(switch_req), 32'd1);
        rst = 1'b1; ack = 1'b0;
        tick();
        check_eq("midrst_req", 32'(switch_req), 32'd0);
        check_eq("midrst_valid", 32'(active_valid), 32'd0);
        rst = 1'b0; ack_wait = 0;
        run(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
